display_scan_ctrl: RTL and testbench

- Time-multiplexes a 16-bit value onto a 4-digit common-anode seven-segment display.
- Produces the active-low anode select and the 5-bit digit code consumed by the downstream Cathode_Control decoder.
- Accepts new values through a valid/ready handshake and commits them only at frame boundaries, so the display never tears.
- Shows dashes while the AES core is busy or before the first value arrives.

---
 rtl/display_scan_ctrl_pkg.sv | 19 +
 rtl/display_scan_ctrl_if.sv | 21 ++
 rtl/display_scan_ctrl_refresh_tick_gen.sv | 33 +++
 rtl/display_scan_ctrl.sv | 103 ++++++++++
 tb/tb_display_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Digit codes match what the downstream Cathode_Control decoder expects.
package display_scan_ctrl_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [4:0]  DIG_DASH   = 5'h11;
    localparam logic [4:0]  DIG_P      = 5'h10;

    typedef enum logic {
        WAIT_FIRST,
        SHOW
    } state_e;

    // Pick nibble idx out of a 16-bit value; idx 0 is bits [3:0].
    function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] idx);
        return v[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Load handshake between a value source and the display scan controller.
// The source must hold value_in steady while load_valid is high and load_ready is low.
interface display_scan_ctrl_if;

    logic [15:0] value_in;
    logic        load_valid;
    logic        load_ready;

    modport master (
        output value_in,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  value_in,
        input  load_valid,
        output load_ready
    );

endinterface

// File: rtl/display_scan_ctrl_refresh_tick_gen.sv
// Free-running refresh counter; tick is high in the cycle the count is REFRESH_DIV-1.
// The count wraps to zero on the edge that follows the tick.
module display_scan_ctrl_refresh_tick_gen #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexes a 16-bit value onto a 4-digit common-anode display.
// New values are staged in a one-entry pending register and only committed at frame wraps.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic                      clk,
    input  logic                      rst_n,
    display_scan_ctrl_if.slave        load,
    input  logic                      busy,
    output logic [3:0]                Anode,
    output logic [4:0]                Digit,
    output logic                      frame_tick
);

    logic        tick;
    logic        wrap;
    logic        xfer;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  anode_q, anode_d;
    logic [4:0]  digit_q, digit_d;
    logic        frame_tick_q, frame_tick_d;
    logic        pend_full_q, pend_full_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] disp_q, disp_d;
    state_e      state_q, state_d;

    display_scan_ctrl_refresh_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign wrap            = tick && (idx_q == 2'(NUM_DIGITS - 1));
    assign xfer            = load.load_valid && !pend_full_q;
    assign load.load_ready = !pend_full_q;

    assign Anode      = anode_q;
    assign Digit      = digit_q;
    assign frame_tick = frame_tick_q;

    always_comb begin
        idx_d        = idx_q;
        anode_d      = anode_q;
        digit_d      = digit_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        disp_d       = disp_q;
        state_d      = state_q;
        frame_tick_d = wrap;

        if (xfer) begin
            pend_d      = load.value_in;
            pend_full_d = 1'b1;
        end

        // xfer needs pending empty and commit needs it full, so the two never collide.
        if (wrap && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
            state_d     = SHOW;
        end

        // Digit uses the post-commit value so a new frame starts with the new display.
        if (tick) begin
            idx_d   = idx_q + 2'd1;
            anode_d = ~(4'b0001 << idx_d);
            if (busy || (state_d == WAIT_FIRST)) begin
                digit_d = DIG_DASH;
            end else begin
                digit_d = {1'b0, nibble_sel(disp_d, idx_d)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= 2'd0;
            anode_q      <= 4'b1110;
            digit_q      <= DIG_DASH;
            frame_tick_q <= 1'b0;
            pend_full_q  <= 1'b0;
            pend_q       <= 16'h0000;
            disp_q       <= 16'h0000;
            state_q      <= WAIT_FIRST;
        end else begin
            idx_q        <= idx_d;
            anode_q      <= anode_d;
            digit_q      <= digit_d;
            frame_tick_q <= frame_tick_d;
            pend_full_q  <= pend_full_d;
            pend_q       <= pend_d;
            disp_q       <= disp_d;
            state_q      <= state_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with REFRESH_DIV=4: directed tables and sequences plus
// randomized traffic checked every cycle against an edge-count based reference model.
module tb_display_scan_ctrl;

    localparam int unsigned D = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       busy  = 1'b0;
    logic [3:0] anode;
    logic [4:0] digit;
    logic       frame_tick;

    display_scan_ctrl_if lif ();

    display_scan_ctrl #(
        .REFRESH_DIV (D),
        .CNT_W       (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (lif),
        .busy       (busy),
        .Anode      (anode),
        .Digit      (digit),
        .frame_tick (frame_tick)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        lif.load_valid = 1'b0;
        busy = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference model: everything follows from the number of clock edges since reset.
    int unsigned m_n;
    logic        m_pend;
    logic [15:0] m_pval;
    logic [15:0] m_disp;
    logic        m_shown;
    logic [4:0]  m_digit;
    logic        m_acc;

    initial begin
        m_n = 0; m_pend = 0; m_pval = 0; m_disp = 0; m_shown = 0; m_digit = 5'h11;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_n = 0; m_pend = 0; m_disp = 0; m_shown = 0; m_digit = 5'h11;
            end else begin
                m_n++;
                m_acc = lif.load_valid && !m_pend;
                if ((m_n % (4 * D)) == 0 && m_pend) begin
                    m_disp  = m_pval;
                    m_pend  = 0;
                    m_shown = 1;
                end
                if (m_acc) begin
                    m_pval = lif.value_in;
                    m_pend = 1;
                end
                if ((m_n % D) == 0) begin
                    if (busy || !m_shown) m_digit = 5'h11;
                    else m_digit = {1'b0, m_disp[4 * ((m_n / D) % 4) +: 4]};
                end
            end
        end
    end

    function automatic logic [3:0] m_anode();
        logic [3:0] t;
        t = 4'b0001 << ((m_n / D) % 4);
        return ~t;
    endfunction

    initial forever begin
        @(negedge clk);
        check("model_anode", 32'(anode), 32'(m_anode()));
        check("model_digit", 32'(digit), 32'(m_digit));
        check("model_ready", 32'(lif.load_ready), 32'(!m_pend));
        check("model_ftick", 32'(frame_tick), 32'(m_n > 0 && (m_n % (4 * D)) == 0));
    end

    typedef struct packed {
        logic [15:0]     val;
        logic            bsy;
        logic [3:0][4:0] dig;
    } vec_t;

    vec_t       vecs [5];
    logic [3:0] pat [4];
    logic       rdy_prev;

    initial begin
        pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        vecs[0] = '{16'hA5C3, 1'b0, {5'h0A, 5'h05, 5'h0C, 5'h03}};
        vecs[1] = '{16'h00FF, 1'b0, {5'h00, 5'h00, 5'h0F, 5'h0F}};
        vecs[2] = '{16'hBEEF, 1'b0, {5'h0B, 5'h0E, 5'h0E, 5'h0F}};
        vecs[3] = '{16'h1234, 1'b1, {5'h11, 5'h11, 5'h11, 5'h11}};
        vecs[4] = '{16'h0000, 1'b0, {5'h00, 5'h00, 5'h00, 5'h00}};
        lif.value_in   = 16'h0000;
        lif.load_valid = 1'b0;

        // Reset values, seen without any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_anode", 32'(anode), 'b1110);
        check("rst_digit", 32'(digit), 'h11);
        check("rst_ready", 32'(lif.load_ready), 1);
        check("rst_ftick", 32'(frame_tick), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            check("scan_anode", 32'(anode), 32'(pat[(k / 4) % 4]));
            check("scan_dash", 32'(digit), 'h11);
        end

        // Table: load one value, check a whole frame after the commit.
        foreach (vecs[i]) begin
            do_reset();
            lif.value_in   = vecs[i].val;
            lif.load_valid = 1'b1;
            busy           = vecs[i].bsy;
            step(1);
            lif.load_valid = 1'b0;
            check("tbl_ready_low", 32'(lif.load_ready), 0);
            step(14);
            check("tbl_ready_pre", 32'(lif.load_ready), 0);
            step(1);
            check("tbl_ftick", 32'(frame_tick), 1);
            check("tbl_ready_post", 32'(lif.load_ready), 1);
            for (int d = 0; d < 4; d++) begin
                if (d > 0) step(4);
                check("tbl_anode", 32'(anode), 32'(pat[d]));
                check("tbl_digit", 32'(digit), 32'(vecs[i].dig[d]));
            end
        end

        // Back-to-back loads with valid held high.
        do_reset();
        lif.value_in   = 16'h1234;
        lif.load_valid = 1'b1;
        step(1);
        check("b2b_ready0", 32'(lif.load_ready), 0);
        lif.value_in = 16'hBEEF;
        step(15);
        check("b2b_first", 32'(digit), 'h04);
        check("b2b_ready1", 32'(lif.load_ready), 1);
        step(1);
        check("b2b_accept2", 32'(lif.load_ready), 0);
        lif.load_valid = 1'b0;
        step(11);
        check("b2b_hold", 32'(digit), 'h01);
        step(4);
        check("b2b_second", 32'(digit), 'h0F);
        check("b2b_ftick", 32'(frame_tick), 1);

        // busy mid-frame while showing 00FF.
        do_reset();
        lif.value_in   = 16'h00FF;
        lif.load_valid = 1'b1;
        step(1);
        lif.load_valid = 1'b0;
        step(15);
        check("busy_pre", 32'(digit), 'h0F);
        step(1);
        busy = 1'b1;
        step(3);
        check("busy_dash", 32'(digit), 'h11);
        busy = 1'b0;
        step(4);
        check("busy_resume", 32'(digit), 'h00);
        step(8);
        check("busy_wrap", 32'(digit), 'h0F);

        // Load accepted on the very edge of a wrap.
        do_reset();
        lif.value_in   = 16'hA5C3;
        lif.load_valid = 1'b1;
        step(1);
        lif.load_valid = 1'b0;
        step(30);
        lif.value_in   = 16'h1234;
        lif.load_valid = 1'b1;
        step(1);
        check("coinc_ftick", 32'(frame_tick), 1);
        check("coinc_old", 32'(digit), 'h03);
        check("coinc_ready", 32'(lif.load_ready), 0);
        lif.load_valid = 1'b0;
        step(1);
        check("coinc_ftick_low", 32'(frame_tick), 0);
        step(15);
        check("coinc_ftick2", 32'(frame_tick), 1);
        check("coinc_new", 32'(digit), 'h04);
        check("coinc_ready2", 32'(lif.load_ready), 1);

        // Async reset with a value pending.
        do_reset();
        lif.value_in   = 16'h5555;
        lif.load_valid = 1'b1;
        step(1);
        lif.value_in = 16'h6666;
        step(16);
        lif.load_valid = 1'b0;
        step(5);
        check("arst_pre_anode", 32'(anode), 'b1101);
        check("arst_pre_ready", 32'(lif.load_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_anode", 32'(anode), 'b1110);
        check("arst_digit", 32'(digit), 'h11);
        check("arst_ready", 32'(lif.load_ready), 1);
        check("arst_ftick", 32'(frame_tick), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(16);
        check("arst_lost", 32'(digit), 'h11);
        check("arst_ftick2", 32'(frame_tick), 1);

        // Randomized traffic, checked by the model every cycle.
        do_reset();
        rdy_prev = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                lif.load_valid = 1'b0;
                #2 rst_n = 1'b1;
                rdy_prev = 1'b1;
            end else begin
                if (!(lif.load_valid && !rdy_prev)) begin
                    lif.load_valid = ($urandom_range(0, 2) == 0);
                    lif.value_in   = 16'($urandom);
                end
                if ($urandom_range(0, 29) == 0) busy = ~busy;
                rdy_prev = lif.load_ready;
            end
        end

        step(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
